// File: rtl/alu_seq.sv
// alu_seq: valid/ready command sequencer driving a 32-bit combinational ALU.
// Optional accumulator operand path is enabled by defining ALU_SEQ_ACC_EN.
module alu_seq #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
`ifdef ALU_SEQ_ACC_EN
  input  logic        cmd_use_acc,
`endif
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic        alu_v,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_res,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

  localparam logic [3:0] CntInit = 4'(ALU_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] rsp_res_q, rsp_res_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] op_cnt, op_cnt_d;
  logic [31:0] a_sel;
  logic        op_legal;
  logic        capture;

  assign capture = (state_q == StIssue) && (cnt_q == 4'd0);

`ifdef ALU_SEQ_ACC_EN
  logic [31:0] acc_q, acc_d;

  assign a_sel = cmd_use_acc ? acc_q : cmd_a;

  always_comb begin
    acc_d = acc_q;
    if (capture) acc_d = alu_res;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
`else
  assign a_sel = cmd_a;
`endif

  always_comb begin
    op_legal = 1'b0;
    case (cmd_op)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: op_legal = 1'b1;
      default:                                      op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_res_d   = rsp_res_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    op_cnt_d    = op_cnt;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          alu_a_d  = a_sel;
          alu_b_d  = cmd_b;
          alu_op_d = cmd_op;
          if (op_legal) begin
            state_d = StIssue;
            cnt_d   = CntInit;
          end else begin
            // Illegal op: respond immediately, ALU result is never sampled.
            state_d     = StHold;
            rsp_res_d   = '0;
            rsp_flags_d = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      StIssue: begin
        if (capture) begin
          rsp_res_d   = alu_res;
          rsp_flags_d = {alu_v, alu_z, alu_n, alu_c};
          rsp_err_d   = 1'b0;
          state_d     = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (rsp_ready) begin
          state_d  = StIdle;
          op_cnt_d = op_cnt + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      op_cnt      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      op_cnt      <= op_cnt_d;
    end
  end

  // Ready is held low during reset so nothing is accepted on the reset edge.
  assign cmd_ready = (state_q == StIdle) && !reset;
  assign rsp_valid = (state_q == StHold);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;

endmodule
